// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MUL_LAT_DEFAULT = 4;

endpackage

// File: rtl/mul_latency_counter.sv
// Cycle counter for an iterative MUL/DIV held in EXE; flags the final cycle of the operation.
module mul_latency_counter #(
  parameter int MUL_LAT  = 4,
  parameter int CNT_BITS = $clog2(MUL_LAT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic busy_i,
  output logic last_o
);

  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MUL_LAT - 1);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  assign last_o = busy_i && (cnt_q == LAST_CNT);

  // The start cycle counts as the first EXE cycle, so loading 1 leaves MUL_LAT-1 busy cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CNT_BITS'(1);
    end else if (last_o) begin
      cnt_d = '0;
    end else if (busy_i) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use stall, taken-branch squash and MUL/DIV sequencing for the 5-stage RV32 pipeline.
// Optional perf counters (stall/flush) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ID_rs1_i,
  input  logic [4:0] ID_rs2_i,
  input  logic       ID_uses_rs2_i,
  input  logic [4:0] EXE_rd_i,
  input  logic       EXE_MemRead_i,
  input  logic       EXE_is_mul_i,
  input  logic       EXE_branch_taken_i,
  output logic       PC_write_o,
  output logic       IFID_write_o,
  output logic       IFID_flush_o,
  output logic       IDEX_flush_o,
  output logic       IDEX_hold_o,
  output logic       EXMEM_bubble_o,
  output logic       mul_start_o,
  output logic       mul_valid_o,
  output logic       busy_o
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt_o
  , output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  state_e state_q;
  state_e state_d;
  logic   load_use;
  logic   mul_last;

  assign load_use = EXE_MemRead_i && (EXE_rd_i != REG_ZERO) &&
                    ((EXE_rd_i == ID_rs1_i) || (ID_uses_rs2_i && (EXE_rd_i == ID_rs2_i)));

  mul_latency_counter #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start_o),
    .busy_i  (state_q == BUSY),
    .last_o  (mul_last)
  );

  always_comb begin
    state_d        = state_q;
    PC_write_o     = 1'b0;
    IFID_write_o   = 1'b0;
    IFID_flush_o   = 1'b0;
    IDEX_flush_o   = 1'b0;
    IDEX_hold_o    = 1'b0;
    EXMEM_bubble_o = 1'b0;
    mul_start_o    = 1'b0;
    mul_valid_o    = 1'b0;
    busy_o         = 1'b0;

    if (rst_i) begin
      PC_write_o   = 1'b1;
      IFID_write_o = 1'b1;
    end else begin
      busy_o = (state_q != RUN);
      unique case (state_q)
        RUN: begin
          if (EXE_branch_taken_i) begin
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
            IFID_flush_o = 1'b1;
            IDEX_flush_o = 1'b1;
          end else if (load_use) begin
            IDEX_flush_o = 1'b1;
          end else if (EXE_is_mul_i) begin
            mul_start_o    = 1'b1;
            IDEX_hold_o    = 1'b1;
            EXMEM_bubble_o = 1'b1;
            state_d        = BUSY;
          end else begin
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
          end
        end
        BUSY: begin
          // Branch and load-use inputs are meaningless here: EXE still holds the mul.
          if (mul_last) begin
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
            mul_valid_o  = 1'b1;
            state_d      = RUN;
          end else begin
            IDEX_hold_o    = 1'b1;
            EXMEM_bubble_o = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_write_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (IFID_flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed vector bench for hazard_sequencer (MUL_LAT=4).
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       uses2 = 1'b0, memrd = 1'b0, ismul = 1'b0, br = 1'b0;
  logic       pc_w, ifid_w, ifid_f, idex_f, idex_h, exmem_b, m_start, m_valid, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MUL_LAT(4)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ID_rs1_i           (rs1),
    .ID_rs2_i           (rs2),
    .ID_uses_rs2_i      (uses2),
    .EXE_rd_i           (rd),
    .EXE_MemRead_i      (memrd),
    .EXE_is_mul_i       (ismul),
    .EXE_branch_taken_i (br),
    .PC_write_o         (pc_w),
    .IFID_write_o       (ifid_w),
    .IFID_flush_o       (ifid_f),
    .IDEX_flush_o       (idex_f),
    .IDEX_hold_o        (idex_h),
    .EXMEM_bubble_o     (exmem_b),
    .mul_start_o        (m_start),
    .mul_valid_o        (m_valid),
    .busy_o             (busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o      (stall_cnt)
    , .flush_cnt_o      (flush_cnt)
`endif
  );

  // Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_flush, IDEX_hold,
  //                       EXMEM_bubble, mul_start, mul_valid, busy}
  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic [4:0] rd;
    logic       memrd;
    logic       ismul;
    logic       br;
    logic [8:0] exp;
    logic [8:0] mask;
  } vec_t;

  localparam logic [8:0] ALL    = 9'b111111111;
  localparam logic [8:0] NO_IFW = 9'b101111111;
  localparam logic [8:0] O_RUN  = 9'b110000000;
  localparam logic [8:0] O_LU   = 9'b000100000;
  localparam logic [8:0] O_BR   = 9'b111100000;
  localparam logic [8:0] O_MST  = 9'b000011100;
  localparam logic [8:0] O_MBSY = 9'b000011001;
  localparam logic [8:0] O_MEND = 9'b110000011;

  function automatic vec_t mk(string n, logic r, logic [4:0] s1, logic [4:0] s2, logic u2,
                              logic [4:0] d, logic mr, logic mu, logic b,
                              logic [8:0] e, logic [8:0] m);
    vec_t v;
    v.name = n; v.rst = r; v.rs1 = s1; v.rs2 = s2; v.uses2 = u2; v.rd = d;
    v.memrd = mr; v.ismul = mu; v.br = b; v.exp = e; v.mask = m;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [8:0] act;
    @(posedge clk);
    #1;
    rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; uses2 = v.uses2; rd = v.rd;
    memrd = v.memrd; ismul = v.ismul; br = v.br;
    #3;
    act = {pc_w, ifid_w, ifid_f, idex_f, idex_h, exmem_b, m_start, m_valid, busy};
    vectors++;
    if (((act ^ v.exp) & v.mask) != 9'd0) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (mask %b)", v.name, act, v.exp, v.mask);
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk("reset",          1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN, ALL);
    tbl[1]  = mk("idle_alu_dep",   0, 5'd5, 5'd0, 0, 5'd5, 0, 0, 0, O_RUN, ALL);
    tbl[2]  = mk("lw_x5_rs1",      0, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, O_LU,  ALL);
    tbl[3]  = mk("after_lw",       0, 5'd6, 5'd1, 1, 5'd5, 0, 0, 0, O_RUN, ALL);
    tbl[4]  = mk("lw_x0",          0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, O_RUN, ALL);
    tbl[5]  = mk("lw_rs2_unused",  0, 5'd3, 5'd7, 0, 5'd7, 1, 0, 0, O_RUN, ALL);
    tbl[6]  = mk("lw_rs2_used",    0, 5'd3, 5'd7, 1, 5'd7, 1, 0, 0, O_LU,  ALL);
    tbl[7]  = mk("br_over_lu",     0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 1, O_BR,  NO_IFW);
    tbl[8]  = mk("br_alone",       0, 5'd1, 5'd2, 1, 5'd9, 0, 0, 1, O_BR,  NO_IFW);
    tbl[9]  = mk("br_over_mul",    0, 5'd1, 5'd2, 1, 5'd9, 0, 1, 1, O_BR,  NO_IFW);
    tbl[10] = mk("lu_over_mul",    0, 5'd9, 5'd2, 1, 5'd9, 1, 1, 0, O_LU,  ALL);
    tbl[11] = mk("idle_again",     0, 5'd1, 5'd2, 1, 5'd9, 0, 0, 0, O_RUN, ALL);

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // MUL held in EXE for 4 cycles; branch/load-use during BUSY must be ignored.
    apply(mk("mul_c0_start",  0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, O_MST,  ALL));
    apply(mk("mul_c1_busy",   0, 5'd3, 5'd2, 1, 5'd3, 1, 1, 0, O_MBSY, ALL));
    apply(mk("mul_c2_br_ign", 0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 1, O_MBSY, ALL));
    apply(mk("mul_c3_valid",  0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, O_MEND, ALL));
    // Second mul enters right after mul_valid, then reset aborts it in BUSY cycle 2.
    apply(mk("mul2_c0_start", 0, 5'd1, 5'd2, 1, 5'd4, 0, 1, 0, O_MST,  ALL));
    apply(mk("mul2_c1_busy",  0, 5'd1, 5'd2, 1, 5'd4, 0, 1, 0, O_MBSY, ALL));
    apply(mk("mul2_c2_rst",   1, 5'd1, 5'd2, 1, 5'd4, 0, 1, 0, O_RUN,  ALL));
    apply(mk("post_rst_run",  0, 5'd1, 5'd2, 1, 5'd4, 0, 0, 0, O_RUN,  ALL));
    apply(mk("post_rst_idle", 0, 5'd1, 5'd2, 1, 5'd4, 0, 0, 0, O_RUN,  ALL));

`ifdef HAZARD_PERF_CNT_EN
    apply(mk("perf_rst",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN,  ALL));
    apply(mk("perf_lu",       0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, O_LU,   ALL));
    apply(mk("perf_lu_next",  0, 5'd6, 5'd0, 0, 5'd5, 0, 0, 0, O_RUN,  ALL));
    apply(mk("perf_br_lu",    0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 1, O_BR,   NO_IFW));
    apply(mk("perf_mul_c0",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, O_MST,  ALL));
    apply(mk("perf_mul_c1",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, O_MBSY, ALL));
    apply(mk("perf_mul_c2",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, O_MBSY, ALL));
    apply(mk("perf_mul_c3",   0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, O_MEND, ALL));
    apply(mk("perf_idle",     0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, O_RUN,  ALL));
    vectors++;
    if (stall_cnt != 16'd4) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d expected 4", stall_cnt);
    end
    vectors++;
    if (flush_cnt != 16'd1) begin
      miscompares++;
      $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
